// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Resolves data-memory waits, taken-branch flushes and load-use hazards,
// in that priority order, and drives the advance/flush/bubble controls of
// the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. A watchdog sets
// a sticky error when a memory access stays outstanding for MEM_WAIT_MAX
// cycles in MEM_WAIT.
// Optional feature: define PIPE_PERF_CNT_EN to add saturating stall-cycle
// and branch-flush performance counters (StallCycles_Out, FlushCount_Out).
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 16,  // legal range 2..255
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [4:0]           ID_Rs_In,
  input  logic [4:0]           ID_Rt_In,
  input  logic                 ID_UsesRt_In,
  input  logic                 EX_MemRead_In,
  input  logic [4:0]           EX_Rd_In,
  input  logic                 EX_BranchTaken_In,
  input  logic                 MEM_Req_In,
  input  logic                 MEM_Ready_In,
  output logic                 PC_WriteEN_Out,
  output logic                 IFID_WriteEN_Out,
  output logic                 IDEX_WriteEN_Out,
  output logic                 EXMEM_WriteEN_Out,
  output logic                 IFID_Flush_Out,
  output logic                 IDEX_Flush_Out,
  output logic                 MEMWB_Bubble_Out,
  output logic [1:0]           State_Out,
  output logic                 Error_Out
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] StallCycles_Out,
  output logic [CNT_WIDTH-1:0] FlushCount_Out
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  // Wide enough to hold MEM_WAIT_MAX itself (saturation value).
  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err;

  logic mem_blocked;
  logic rs_match;
  logic rt_match;
  logic hazard;
  logic branch_flush;
  logic load_stall;

  // Event decode. Once in MEM_WAIT the access is known to be outstanding,
  // so only MEM_Ready_In matters there; elsewhere a stall needs a request.
  always_comb begin
    mem_blocked  = (state == ST_MEM_WAIT) ? !MEM_Ready_In
                                          : (MEM_Req_In && !MEM_Ready_In);
    rs_match     = (EX_Rd_In == ID_Rs_In);
    rt_match     = ID_UsesRt_In && (EX_Rd_In == ID_Rt_In);
    // Register 0 is hard-wired, so a load targeting it never conflicts.
    // The cycle right after a load-use stall must not re-detect the same
    // pair, otherwise the bubble would be inserted twice.
    hazard       = EX_MemRead_In && (EX_Rd_In != 5'd0) && (rs_match || rt_match)
                   && (state != ST_LOAD_STALL);
    branch_flush = !mem_blocked && EX_BranchTaken_In;
    load_stall   = !mem_blocked && !EX_BranchTaken_In && hazard;
  end

  // Pipeline register controls, prioritised memory > branch > load-use.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    PC_WriteEN_Out    = 1'b1;
    IFID_WriteEN_Out  = 1'b1;
    IDEX_WriteEN_Out  = 1'b1;
    EXMEM_WriteEN_Out = 1'b1;
    IFID_Flush_Out    = 1'b0;
    IDEX_Flush_Out    = 1'b0;
    MEMWB_Bubble_Out  = 1'b0;
    if (RESET) begin
      // Keep clocking NOPs into every stage while reset is held.
      IFID_Flush_Out   = 1'b1;
      IDEX_Flush_Out   = 1'b1;
      MEMWB_Bubble_Out = 1'b1;
    end else if (mem_blocked) begin
      // Freeze everything; MEM/WB gets a bubble so the stalled access
      // does not write back repeatedly.
      PC_WriteEN_Out    = 1'b0;
      IFID_WriteEN_Out  = 1'b0;
      IDEX_WriteEN_Out  = 1'b0;
      EXMEM_WriteEN_Out = 1'b0;
      MEMWB_Bubble_Out  = 1'b1;
    end else if (branch_flush) begin
      // PC still advances so the branch target is loaded; the two
      // wrong-path instructions behind the branch are squashed.
      IFID_Flush_Out = 1'b1;
      IDEX_Flush_Out = 1'b1;
    end else if (load_stall) begin
      // Hold the consumer in ID and send a NOP down to EX for one cycle.
      PC_WriteEN_Out   = 1'b0;
      IFID_WriteEN_Out = 1'b0;
      IDEX_Flush_Out   = 1'b1;
    end
  end

  // Status outputs read as reset values while RESET is asserted, even
  // before the synchronous reset has taken effect on the registers.
  always_comb begin
    State_Out = RESET ? ST_RUN : state;
    Error_Out = !RESET && err;
  end

  // Sequencer state, memory-wait watchdog and sticky timeout flag.
  always_ff @(posedge CLOCK) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked
    // block and the sensitivity list carries only the clock edge.
    if (RESET) begin
      // NOTE: state registers use non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state    <= ST_RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (mem_blocked) begin
      state <= ST_MEM_WAIT;
      if (state == ST_MEM_WAIT) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + WAIT_ONE;
        end
        // Counter reaches WAIT_MAX on this edge (or already sits there).
        if (wait_cnt >= WAIT_MAX - WAIT_ONE) begin
          err <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end else if (load_stall) begin
      state <= ST_LOAD_STALL;
    end else begin
      state <= ST_RUN;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  // Saturating counters of frozen-PC cycles and of branch flushes.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_WriteEN_Out && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (branch_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

  // Counters read as zero while reset is held.
  always_comb begin
    StallCycles_Out = RESET ? '0 : stall_cnt;
    FlushCount_Out  = RESET ? '0 : flush_cnt;
  end
`endif

endmodule
